// File: rtl/caravel_instr_ram_pkg.sv
// Shared constants and address-decode type for the rvj1 instruction RAM.
package caravel_instr_ram_pkg;

    localparam logic [31:0] IRAM_ADDR_BASE = 32'h3000_0000;
    localparam logic [31:0] CTRL_OFFSET    = 32'h0000_1000;
    localparam logic [31:0] WINDOW_SIZE    = 32'h0000_2000;

    localparam int WORD_W    = 32;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_CTRL,
        DEC_UNMAPPED
    } dec_e;

endpackage

// File: rtl/instr_ram_dp.sv
// Dual-port word RAM: port A read/write with byte enables, port B read-only.
module instr_ram_dp
    import caravel_instr_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 a_en,
    input  logic                 a_we,
    input  logic [NUM_LANES-1:0] a_sel,
    input  logic [AW-1:0]        a_addr,
    input  logic [WORD_W-1:0]    a_wdata,
    output logic [WORD_W-1:0]    a_rdata,
    input  logic                 b_en,
    input  logic [AW-1:0]        b_addr,
    output logic [WORD_W-1:0]    b_rdata
);

    logic [WORD_W-1:0] mem [0:DEPTH_WORDS-1];

    always_ff @(posedge wb_clk_i) begin
        if (a_en) begin
            if (a_we) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (a_sel[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
            a_rdata <= mem[a_addr];
        end
    end

    // Nonblocking read of mem gives the core the pre-write word on a collision.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            b_rdata <= '0;
        end else if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/caravel_instr_ram.sv
// Wishbone instruction RAM for rvj1 with core fetch port and core reset control.
// Optional CTRL register enabled by defining CORE_RST_CTRL_EN.
module caravel_instr_ram
    import caravel_instr_ram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = IRAM_ADDR_BASE,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          AW          = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              instr_req_i,
    input  logic [AW-1:0]     instr_addr_i,
    output logic [WORD_W-1:0] instr_rdata_o,
    output logic              core_rst_o
);

    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic              ack_q;
    dec_e              dec, dec_q;
    logic              req;
    logic [31:0]       offset;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] ctrl_word;
    logic              ctrl_hit;

    assign req    = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign offset = wbs_adr_i - ADDR_BASE;

`ifdef CORE_RST_CTRL_EN
    logic core_rst_q;
    assign ctrl_hit = (offset[31:2] == CTRL_OFFSET[31:2]);
`else
    assign ctrl_hit = 1'b0;
`endif

    // Addresses outside the window fall to UNMAPPED so every access is acked.
    always_comb begin
        dec = DEC_UNMAPPED;
        if (offset < RAM_BYTES) dec = DEC_RAM;
        else if (ctrl_hit)      dec = DEC_CTRL;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dec_q <= DEC_UNMAPPED;
        end else begin
            ack_q <= req;
            if (req) dec_q <= dec;
        end
    end

`ifdef CORE_RST_CTRL_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            core_rst_q <= 1'b1;
        end else if (req && dec == DEC_CTRL && wbs_we_i && wbs_sel_i[0]) begin
            core_rst_q <= wbs_dat_i[0];
        end
    end
    assign ctrl_word  = {31'b0, core_rst_q};
    assign core_rst_o = core_rst_q | wb_rst_i;
`else
    assign ctrl_word  = '0;
    assign core_rst_o = wb_rst_i;
`endif

    instr_ram_dp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .a_en     (req & ~wb_rst_i & (dec == DEC_RAM)),
        .a_we     (wbs_we_i),
        .a_sel    (wbs_sel_i),
        .a_addr   (wbs_adr_i[AW+1:2]),
        .a_wdata  (wbs_dat_i),
        .a_rdata  (ram_rdata),
        .b_en     (instr_req_i),
        .b_addr   (instr_addr_i),
        .b_rdata  (instr_rdata_o)
    );

    always_comb begin
        wbs_dat_o = '0;
        if (ack_q) begin
            case (dec_q)
                DEC_RAM:  wbs_dat_o = ram_rdata;
                DEC_CTRL: wbs_dat_o = ctrl_word;
                default:  wbs_dat_o = '0;
            endcase
        end
    end

    assign wbs_ack_o = ack_q;

endmodule

// File: tb/tb_caravel_instr_ram.sv
// Self-checking bench for caravel_instr_ram: directed plan plus randomized traffic vs. a memory model.
module tb_caravel_instr_ram;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef CORE_RST_CTRL_EN
    localparam bit CTRL_EN = 1'b1;
`else
    localparam bit CTRL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        ireq;
    logic [9:0]  iaddr;
    logic [31:0] irdata;
    logic        core_rst;

    always #5 clk = ~clk;

    caravel_instr_ram dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat_w),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_r),
        .instr_req_i   (ireq),
        .instr_addr_i  (iaddr),
        .instr_rdata_o (irdata),
        .core_rst_o    (core_rst)
    );

    bit   [31:0] mem_m [1024];
    bit          ctrl_m;
    logic [31:0] last_core;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        if (off < 32'd4096) return mem_m[off[11:2]];
        if (CTRL_EN && off[31:2] == 30'h400) return {31'b0, ctrl_m};
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off = a - BASE;
        if (off < 32'd4096) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mem_m[off[11:2]][8*i +: 8] = d[8*i +: 8];
        end else if (CTRL_EN && off[31:2] == 30'h400 && s[0]) begin
            ctrl_m = d[0];
        end
    endfunction

    function automatic logic exp_core_rst();
        return CTRL_EN ? ctrl_m : 1'b0;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after ack.
    task automatic wb_access(input string tag, input logic [31:0] a, input logic w,
                             input logic [3:0] s, input logic [31:0] d,
                             input logic creq, input logic [9:0] caddr,
                             output logic [31:0] rd);
        int cycles;
        logic [31:0] exp_rd;
        cyc = 1; stb = 1; we = w; sel = s; adr = a; dat_w = d;
        ireq = creq; iaddr = caddr;
        exp_rd = w ? 32'h0 : model_read(a);
        if (creq) last_core = mem_m[caddr];
        @(posedge clk); #1;
        ireq = 0;
        chk({tag, "/core"}, irdata, last_core);
        cycles = 1;
        while (!ack && cycles < 8) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, "/ack_lat"}, cycles, 1);
        rd = dat_r;
        if (!w) chk({tag, "/rdata"}, dat_r, exp_rd);
        cyc = 0; stb = 0; we = 0;
        if (w) model_write(a, d, s);
        @(posedge clk); #1;
        chk({tag, "/ack_drop"}, ack, 0);
    endtask

    task automatic core_fetch(input string tag, input logic [9:0] caddr);
        ireq = 1; iaddr = caddr;
        last_core = mem_m[caddr];
        @(posedge clk); #1;
        ireq = 0;
        chk(tag, irdata, last_core);
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        ireq = 0; iaddr = 0;
        ctrl_m = 1; last_core = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/core_rst_in_reset", core_rst, 1);
        rst = 0;
        @(posedge clk); #1;
        chk("rst/core_rst", core_rst, exp_core_rst());
        chk("rst/ack", ack, 0);
        chk("rst/dat", dat_r, 0);
        chk("rst/irdata", irdata, 0);

        wb_access("full_wr", BASE, 1, 4'hF, 32'h0000_AB60, 0, 0, rd);
        wb_access("full_rd", BASE, 0, 4'hF, 0, 0, 0, rd);
        chk("full_rd/value", rd, 32'h0000_AB60);

        wb_access("lane_wr1", BASE + 4, 1, 4'b1111, 32'hFFFF_FFFF, 0, 0, rd);
        wb_access("lane_wr2", BASE + 4, 1, 4'b0101, 32'h1234_5678, 0, 0, rd);
        wb_access("lane_rd", BASE + 4, 0, 4'b0010, 0, 0, 0, rd);
        chk("lane_rd/value", rd, 32'hFF34_FF78);

        for (int i = 0; i < 1024; i++)
            wb_access("sweep_wr", BASE + 32'(i * 4), 1, 4'hF, 32'(i), 0, 0, rd);
        for (int i = 0; i < 1024; i++)
            wb_access("sweep_rd", BASE + 32'(i * 4), 0, 4'hF, 0, 0, 0, rd);
        wb_access("last_word", BASE + 32'h0FFC, 0, 4'hF, 0, 0, 0, rd);
        chk("last_word/value", rd, 32'd1023);
        wb_access("unmapped", BASE + 32'h1004, 0, 4'hF, 0, 0, 0, rd);
        chk("unmapped/value", rd, 0);

        wb_access("ctrl_rd", BASE + 32'h1000, 0, 4'hF, 0, 0, 0, rd);
        wb_access("ctrl_wr0", BASE + 32'h1000, 1, 4'h1, 0, 0, 0, rd);
        chk("ctrl_wr0/core_rst", core_rst, exp_core_rst());
        wb_access("ctrl_rd0", BASE + 32'h1000, 0, 4'hF, 0, 0, 0, rd);

        wb_access("full_wr0", BASE, 1, 4'hF, 32'h0000_AB60, 0, 0, rd);
        core_fetch("fetch0", 10'd0);
        chk("fetch0/value", irdata, 32'h0000_AB60);

        wb_access("collide", BASE + 20, 1, 4'hF, 32'h0000_AB61, 1, 10'd5, rd);
        chk("collide/old", last_core, 32'd5);
        core_fetch("collide_after", 10'd5);
        chk("collide_after/value", irdata, 32'h0000_AB61);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int kind = $urandom_range(0, 9);
            if (kind < 7)       a = BASE + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            else if (kind == 7) a = BASE + 32'h1000;
            else                a = BASE + 32'h1004 + {$urandom_range(0, 2046), 2'b00};
            wb_access("rand", a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), rd);
            chk("rand/core_rst", core_rst, exp_core_rst());
        end

        // Reset on the ack edge of a write: the write must be lost.
        rst = 1; cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE + 8; dat_w = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("rst_mid/ack", ack, 0);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        rst = 0;
        ctrl_m = 1; last_core = 0;
        @(posedge clk); #1;
        chk("rst_mid/core_rst", core_rst, exp_core_rst());
        chk("rst_mid/irdata", irdata, 0);
        wb_access("rst_mid_rd", BASE + 8, 0, 4'hF, 0, 0, 0, rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/caravel_instr_ram.md
# caravel_instr_ram

Wishbone-slave instruction memory in the Caravel user project area for the rvj1 core. The management SoC firmware loads and reads back the program image over the user Wishbone port. The rvj1 core fetches from a second, read-only port. A control register holds the core in reset while the image loads.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h3000_0000: user-area base address.
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words (power of two).
- `AW`, default 10: word-address width, log2(DEPTH_WORDS).

Ports:
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte lane selects.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `instr_req_i` in 1: core fetch request.
- `instr_addr_i` in AW: core fetch word address.
- `instr_rdata_o` out 32: fetched instruction.
- `core_rst_o` out 1: active-high reset to the rvj1 core.

## Operation
- Decode on `wbs_adr_i`:
  - RAM window: ADDR_BASE to ADDR_BASE + 4·DEPTH_WORDS − 1. Word index is `wbs_adr_i[AW+1:2]`.
  - CTRL register: ADDR_BASE + 32'h1000, bit0 = core_rst.
  - Any other address inside ADDR_BASE + [0, 0x2000): acked, reads 0, writes ignored. The bus never hangs.
- RAM write: only the byte lanes whose `wbs_sel_i` bit is set are updated.
- RAM read: returns the full word regardless of `wbs_sel_i`.
- CTRL write: bit0 is written when `wbs_sel_i[0]` is set. CTRL read returns {31'b0, core_rst}.
- `core_rst_o` = core_rst OR `wb_rst_i`.
- Core port:
  - When `instr_req_i` is high, the word at `instr_addr_i` appears on `instr_rdata_o` on the next edge.
  - When `instr_req_i` is low, `instr_rdata_o` holds its last value.
- Reset values:
  - `wbs_ack_o` = 0.
  - `wbs_dat_o` = 0.
  - `instr_rdata_o` = 0.
  - core_rst = 1.
  - RAM contents are not reset; they are undefined until written.

## Timing
- Wishbone classic single-cycle handshake:
  - A request is cyc & stb & !ack_q.
  - Ack is registered: it asserts exactly one cycle after the request is sampled and lasts one cycle.
  - Read data is valid in the same cycle as ack.
- Ack is never high on two consecutive cycles. Back-to-back accesses therefore take at least 2 cycles each.
- Writes take effect at the same edge that raises ack.
- Core read latency is 1 cycle; the core port has no stall.
- Simultaneous Wishbone write and core read of the same word: the core receives the old data (read-before-write).
- Simultaneous Wishbone read and core read: both are served with no conflict (true dual-read).
- Reset asserted mid-transaction: the pending ack is dropped and the access is lost. A write is committed only if its ack edge has already occurred.
- If stb is deasserted before ack, the access is still completed internally; masters must not do this.

## Configuration
- `CORE_RST_CTRL_EN` defined:
  - The CTRL register exists as described.
  - `core_rst_o` resets to 1 and is released by firmware writing 0.
- `CORE_RST_CTRL_EN` undefined:
  - No CTRL register; its address behaves like an unmapped address (reads 0, writes ignored).
  - `core_rst_o` = `wb_rst_i`.

## Structure
- Package `caravel_instr_ram_pkg` holds:
  - ADDR_BASE, the CTRL offset (0x1000) and the window size (0x2000).
  - Word width 32 and byte-lane count 4.
  - Address decode enum: RAM, CTRL, UNMAPPED.
- One sub-module `instr_ram_dp`: dual-port memory.
  - Port A is read/write with byte enables (Wishbone).
  - Port B is read-only (core).
  - Both ports are synchronous and use `wb_clk_i`.
- Top level contains the decode, ack/read-data registers and CTRL logic.

## Test plan
- Reset release: after `wb_rst_i` falls → `core_rst_o` = 1, `wbs_ack_o` = 0, `wbs_dat_o` = 0.
- Full-word access: write 32'h0000_AB60 to 0x3000_0000, then read it → ack 1 cycle after stb; read returns 32'h0000_AB60.
- Byte lanes: write 32'hFFFF_FFFF to 0x3000_0004 with sel 4'b1111, then write 32'h1234_5678 with sel 4'b0101 → read returns 32'hFF34_FF78.
- RAM sweep:
  - Write the word index to all 1024 words, then read each back → all match.
  - Read 0x3000_0FFC → returns 1023.
  - Read 0x3000_1004 → returns 0 with ack.
- Core release and fetch:
  - Write 0 to CTRL → `core_rst_o` = 0 on the next cycle.
  - Core reads word 0 → `instr_rdata_o` = 32'h0000_AB60 one cycle after the request.
- Collision: same-cycle Wishbone write of 32'hAB61 to word 5 (previously 5) and core read of word 5 → core sees 5; a core read one cycle later sees 32'hAB61.
